// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce FSM and long-press detector.
// Emits a debounced level plus one-cycle press, release and long-press strobes.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
  localparam logic [LW-1:0] LONG_ONE  = LW'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHK,
    HELD,
    RELEASE_CHK
  } state_t;

  state_t          state_reg;
  logic [1:0]      sync_reg;
  logic [DW-1:0]   deb_cnt_reg;
  logic [LW-1:0]   hold_cnt_reg;
  logic            long_done_reg;
  logic            pressed;

  // Synchroniser flops reset to the released (high) level.
  always_ff @(posedge clk) begin
    if (reset) sync_reg <= 2'b11;
    else       sync_reg <= {sync_reg[0], btn_n};
  end

  assign pressed = ~sync_reg[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RELEASED;
      deb_cnt_reg   <= '0;
      hold_cnt_reg  <= '0;
      long_done_reg <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      case (state_reg)
        RELEASED: begin
          if (pressed) begin
            state_reg   <= PRESS_CHK;
            deb_cnt_reg <= '0;
          end
        end
        PRESS_CHK: begin
          if (!pressed) begin
            state_reg   <= RELEASED;
            deb_cnt_reg <= '0;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_reg     <= HELD;
            deb_cnt_reg   <= '0;
            btn_level     <= 1'b1;
            press_pulse   <= 1'b1;
            hold_cnt_reg  <= '0;
            long_done_reg <= 1'b0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_ONE;
          end
        end
        HELD: begin
          if (pressed) begin
            // Hold counter saturates at its last value so the strobe fires only once.
            if (hold_cnt_reg == LONG_LAST) begin
              if (!long_done_reg) begin
                long_pulse    <= 1'b1;
                long_done_reg <= 1'b1;
              end
            end else begin
              hold_cnt_reg <= hold_cnt_reg + LONG_ONE;
            end
          end else begin
            state_reg   <= RELEASE_CHK;
            deb_cnt_reg <= '0;
          end
        end
        RELEASE_CHK: begin
          if (pressed) begin
            state_reg <= HELD;
          end else if (deb_cnt_reg == DEB_LAST) begin
            state_reg     <= RELEASED;
            deb_cnt_reg   <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + DEB_ONE;
          end
        end
        default: state_reg <= RELEASED;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: scenario table, a reset-mid-hold sequence and
// randomized bouncing input checked against a run-length reference model.
module tb_btn_debounce;
  localparam int D = 4;
  localparam int L = 10;
  localparam int NE = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_n = 1'b1;
  logic btn_level, press_pulse, release_pulse, long_pulse;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  btn_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk(clk),
    .reset(reset),
    .btn_n(btn_n),
    .btn_level(btn_level),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse)
  );

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Scenario table: btn_n per edge (bit e = value sampled at edge e) and expected strobe edges.
  typedef struct {
    string       name;
    logic [NE-1:0] pat;
    int          press_e;
    int          release_e;
    int          long_e;
  } scen_t;

  scen_t tbl[6];

  // Reference model: pressed samples reach the FSM two edges late; a level change needs
  // D+1 consecutive equal samples; long-press counts pressed samples following a pressed one.
  logic [1:0] m_hist = 2'b11;
  int  ones_run = 0, zeros_run = 0, held = 0;
  logic m_level = 1'b0, m_long_done = 1'b0, prev_p = 1'b0;
  logic exp_press, exp_rel, exp_long;

  task automatic model_step(input logic rst, input logic b);
    logic p;
    exp_press = 1'b0;
    exp_rel   = 1'b0;
    exp_long  = 1'b0;
    if (rst) begin
      m_hist = 2'b11;
      ones_run = 0;
      zeros_run = 0;
      held = 0;
      m_level = 1'b0;
      m_long_done = 1'b0;
      prev_p = 1'b0;
    end else begin
      p = !m_hist[1];
      m_hist = {m_hist[0], b};
      if (p) begin ones_run++; zeros_run = 0; end
      else   begin zeros_run++; ones_run = 0; end
      if (!m_level && ones_run >= D + 1) begin
        m_level = 1'b1;
        exp_press = 1'b1;
        held = 0;
        m_long_done = 1'b0;
      end else if (m_level && zeros_run >= D + 1) begin
        m_level = 1'b0;
        exp_rel = 1'b1;
      end else if (m_level && p && prev_p) begin
        if (held < L) held++;
        if (held == L && !m_long_done) begin
          exp_long = 1'b1;
          m_long_done = 1'b1;
        end
      end
      prev_p = p;
    end
  endtask

  initial begin
    int fails_before;
    int cyc;
    int burst;
    logic cur;

    tbl[0] = '{"clean_press",    40'h00_0000_0000, 6, -1, 16};
    tbl[1] = '{"bounce_restart", 40'h00_0000_0004, 9, -1, 19};
    tbl[2] = '{"press_release",  40'hFF_FFF0_0000, 6, 26, 16};
    tbl[3] = '{"release_glitch", 40'h00_0000_0C00, 6, -1, 19};
    tbl[4] = '{"short_reject",   40'hFF_FFFF_FFF0, -1, -1, -1};
    tbl[5] = '{"min_press",      40'hFF_FFFF_FFE0, 6, 11, -1};

    for (int s = 0; s < 6; s++) begin
      fails_before = n_fail;
      @(negedge clk);
      reset = 1'b1;
      btn_n = 1'b1;
      @(posedge clk); #1;
      check("reset_level", btn_level, 1'b0);
      check("reset_press", press_pulse, 1'b0);
      check("reset_release", release_pulse, 1'b0);
      check("reset_long", long_pulse, 1'b0);
      for (int e = 0; e < NE; e++) begin
        @(negedge clk);
        reset = 1'b0;
        btn_n = tbl[s].pat[e];
        @(posedge clk); #1;
        check({tbl[s].name, "_level"}, btn_level,
              tbl[s].press_e >= 0 && e >= tbl[s].press_e &&
              (tbl[s].release_e < 0 || e < tbl[s].release_e));
        check({tbl[s].name, "_press"}, press_pulse, e == tbl[s].press_e);
        check({tbl[s].name, "_release"}, release_pulse, e == tbl[s].release_e);
        check({tbl[s].name, "_long"}, long_pulse, e == tbl[s].long_e);
      end
      $display("scenario %-15s press@%0d release@%0d long@%0d errors=%0d",
               tbl[s].name, tbl[s].press_e, tbl[s].release_e, tbl[s].long_e,
               n_fail - fails_before);
    end

    // Reset while HELD with the button still down, then a fresh debounce.
    fails_before = n_fail;
    @(negedge clk);
    reset = 1'b1;
    btn_n = 1'b0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
    end
    check("pre_reset_held", btn_level, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("midheld_rst_level", btn_level, 1'b0);
    check("midheld_rst_press", press_pulse, 1'b0);
    check("midheld_rst_release", release_pulse, 1'b0);
    check("midheld_rst_long", long_pulse, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      check("post_rst_press", press_pulse, e == 7);
      check("post_rst_level", btn_level, e >= 7);
      check("post_rst_release", release_pulse, 1'b0);
    end
    $display("sequence reset_mid_held errors=%0d", n_fail - fails_before);

    // Randomized bursts with short bounces, long holds and occasional resets.
    fails_before = n_fail;
    cur = 1'b1;
    burst = 0;
    for (cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (cyc < 2) reset = 1'b1;
      else reset = ($urandom_range(0, 299) == 0);
      if (burst == 0) begin
        cur = ~cur;
        burst = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(1, 24);
      end
      burst--;
      btn_n = cur;
      @(posedge clk);
      model_step(reset, btn_n);
      #1;
      check("rnd_level", btn_level, m_level);
      check("rnd_press", press_pulse, exp_press);
      check("rnd_release", release_pulse, exp_rel);
      check("rnd_long", long_pulse, exp_long);
      check("rnd_onehot", $countones({press_pulse, release_pulse, long_pulse}) <= 1, 1'b1);
    end
    $display("random phase cycles=4000 errors=%0d", n_fail - fails_before);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
